// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and segment patterns for the seven-segment tick counter.
// Rev 1.0
`default_nettype none

package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_COUNT = SEG_G + 1;

  typedef logic [SEG_COUNT-1:0] seg_t;
  typedef logic [3:0]           digit_t;
  typedef logic [2:0]           phase_t;

  localparam phase_t PHASE_LAST = 3'd5;

  function automatic seg_t seg_bit(input int idx);
    seg_bit = seg_t'(1) << idx;
  endfunction

  // Entry 0 sits in the least significant slice: index with the digit value.
  localparam logic [15:0][SEG_COUNT-1:0] DIGIT_PAT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [5:0][SEG_COUNT-1:0] SPIN_PAT = {
    seg_bit(SEG_F), seg_bit(SEG_E), seg_bit(SEG_D),
    seg_bit(SEG_C), seg_bit(SEG_B), seg_bit(SEG_A)
  };

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// seg7_decode: combinational pattern select, digit glyph or single spinner segment.
// Rev 1.0
`default_nettype none

module seg7_decode
  import seg7_pkg::*;
(
  input  logic   mode,
  input  digit_t digit,
  input  phase_t phase,
  output seg_t   pattern
);

  seg_t spin;

  always_comb begin
    spin = '0;
    case (phase)
      3'd0:    spin = SPIN_PAT[0];
      3'd1:    spin = SPIN_PAT[1];
      3'd2:    spin = SPIN_PAT[2];
      3'd3:    spin = SPIN_PAT[3];
      3'd4:    spin = SPIN_PAT[4];
      3'd5:    spin = SPIN_PAT[5];
      default: spin = '0;
    endcase
  end

  always_comb begin
    pattern = spin;
    if (mode) begin
      pattern = DIGIT_PAT[digit];
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg7_tick_counter.sv
// seg7_tick_counter: prescaled modulo-N digit counter and 6-phase spinner on a 7-seg display.
// Rev 1.0 -- SEG7_COMMON_ANODE_EN inverts seg/dp for common-anode displays.
`default_nettype none

module seg7_tick_counter
  import seg7_pkg::*;
#(
  parameter int PRESCALE_W = 16,
  parameter int TICK_DIV   = 1024,
  parameter int COUNT_MOD  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic       up_down,
  input  logic       clear,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] digit,
  output logic       wrap
);

`ifdef SEG7_COMMON_ANODE_EN
  localparam logic INVERT = 1'b1;
`else
  localparam logic INVERT = 1'b0;
`endif

  localparam seg_t                  SEG_MASK = {SEG_COUNT{INVERT}};
  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(TICK_DIV - 1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE  = PRESCALE_W'(1);
  localparam digit_t                DIG_LAST = digit_t'(COUNT_MOD - 1);

  logic [PRESCALE_W-1:0] presc;
  phase_t                phase;
  logic                  dp_state;
  logic                  tick;
  digit_t                digit_nxt;
  phase_t                phase_nxt;
  logic                  roll;
  seg_t                  pattern;

  assign tick = en && (presc == PRE_LAST);

  // Next digit/phase for a tick in the selected direction; roll flags the wrap.
  always_comb begin
    digit_nxt = digit;
    phase_nxt = phase;
    roll      = 1'b0;
    if (up_down) begin
      roll      = (digit == DIG_LAST);
      digit_nxt = roll ? 4'd0 : digit + 4'd1;
      phase_nxt = (phase == PHASE_LAST) ? 3'd0 : phase + 3'd1;
    end else begin
      roll      = (digit == 4'd0);
      digit_nxt = roll ? DIG_LAST : digit - 4'd1;
      phase_nxt = (phase == 3'd0) ? PHASE_LAST : phase - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if (en) begin
      presc <= tick ? '0 : presc + PRE_ONE;
    end
  end

  // clear outranks a coincident tick, so it never produces a wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit    <= '0;
      phase    <= '0;
      dp_state <= 1'b0;
      wrap     <= 1'b0;
    end else if (clear) begin
      digit    <= '0;
      phase    <= '0;
      dp_state <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (tick) begin
        digit    <= digit_nxt;
        phase    <= phase_nxt;
        dp_state <= ~dp_state;
        wrap     <= roll;
      end
    end
  end

  seg7_decode u_decode (
    .mode    (mode),
    .digit   (digit),
    .phase   (phase),
    .pattern (pattern)
  );

  // seg follows the registered state one clock later and keeps tracking mode while en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_MASK;
    end else begin
      seg <= pattern ^ SEG_MASK;
    end
  end

  assign dp = dp_state ^ INVERT;

endmodule

`default_nettype wire

// File: tb/tb_seg7_tick_counter.sv
// tb_seg7_tick_counter: directed plus randomized checks against an arithmetic reference model.
// Rev 1.0
`default_nettype none

module tb_seg7_tick_counter;

  localparam int TD = 4;
  localparam int CM = 10;

`ifdef SEG7_COMMON_ANODE_EN
  localparam int INV  = 1;
  localparam int MASK = 8'h7F;
`else
  localparam int INV  = 0;
  localparam int MASK = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       up_down;
  logic       clear;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] digit;
  logic       wrap;

  seg7_tick_counter #(
    .PRESCALE_W (16),
    .TICK_DIV   (TD),
    .COUNT_MOD  (CM)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .up_down (up_down),
    .clear   (clear),
    .seg     (seg),
    .dp      (dp),
    .digit   (digit),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  int dtab [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                    'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  int m_pre, m_dig, m_ph, m_dp, m_wrap, m_seg;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_dig = 0; m_ph = 0; m_dp = 0; m_wrap = 0; m_seg = 0;
  endtask

  // One clock of behaviour, computed from the counting rules with modular arithmetic.
  task automatic model_step();
    m_seg = mode ? dtab[m_dig] : (1 << m_ph);
    if (clear) begin
      m_pre = 0; m_dig = 0; m_ph = 0; m_dp = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (en) begin
        if (m_pre == TD - 1) begin
          if (up_down) begin
            m_wrap = (m_dig + 1 == CM) ? 1 : 0;
            m_dig  = (m_dig + 1) % CM;
            m_ph   = (m_ph + 1) % 6;
          end else begin
            m_wrap = (m_dig == 0) ? 1 : 0;
            m_dig  = (m_dig + CM - 1) % CM;
            m_ph   = (m_ph + 5) % 6;
          end
          m_dp = 1 - m_dp;
        end
        m_pre = (m_pre + 1) % TD;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".seg"},   16'(seg),   16'(m_seg ^ MASK));
    chk({tag, ".dp"},    16'(dp),    16'(m_dp ^ INV));
    chk({tag, ".digit"}, 16'(digit), 16'(m_dig));
    chk({tag, ".wrap"},  16'(wrap),  16'(m_wrap));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  int wraps;

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; up_down = 1'b1; clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_seg_blank", 16'(seg), 16'(MASK));
    rst_n = 1'b1;

    cycle("release");
    chk("first_seg", 16'(seg), 16'('h3F ^ MASK));
    run(3, "pre");
    chk("first_tick_digit", 16'(digit), 16'd1);
    cycle("lag");
    chk("first_tick_seg", 16'(seg), 16'('h06 ^ MASK));

    wraps = 0;
    for (int i = 0; i < 40; i++) begin
      cycle("up10");
      if (wrap === 1'b1) wraps++;
    end
    chk("up_wrap_count", 16'(wraps), 16'd1);
    chk("up_end_digit", 16'(digit), 16'd1);

    clear = 1'b1;
    cycle("clr_a");
    clear = 1'b0; up_down = 1'b0;
    run(4, "down");
    chk("down_digit9", 16'(digit), 16'd9);
    chk("down_wrap", 16'(wrap), 16'd1);
    cycle("down_seg9");
    chk("down_seg9_val", 16'(seg), 16'('h6F ^ MASK));
    run(3, "down");
    chk("down_digit8", 16'(digit), 16'd8);
    cycle("down_seg8");
    chk("down_seg8_val", 16'(seg), 16'('h7F ^ MASK));

    mode = 1'b0; up_down = 1'b1; clear = 1'b1;
    cycle("clr_b");
    clear = 1'b0;
    run(30, "spin_cw");
    up_down = 1'b0;
    run(10, "spin_ccw");

    mode = 1'b1; up_down = 1'b1; clear = 1'b1;
    cycle("clr_c");
    clear = 1'b0;
    run(23, "to5");
    chk("pre_clear_digit5", 16'(digit), 16'd5);
    clear = 1'b1;
    cycle("clr_on_tick");
    chk("clr_tick_digit", 16'(digit), 16'd0);
    chk("clr_tick_wrap", 16'(wrap), 16'd0);
    clear = 1'b0;
    run(3, "restart");
    chk("restart_hold", 16'(digit), 16'd0);
    cycle("restart_tick");
    chk("restart_digit1", 16'(digit), 16'd1);

    en = 1'b0;
    run(20, "hold");
    chk("hold_digit", 16'(digit), 16'd1);
    chk("hold_seg", 16'(seg), 16'('h06 ^ MASK));
    en = 1'b1;

    run(6, "pre_async");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("async_hold");
    rst_n = 1'b1;

    for (int i = 0; i < 600; i++) begin
      en    = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 15) == 0) mode    = ~mode;
      if ($urandom_range(0, 31) == 0) up_down = ~up_down;
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
